mcu51_fetch_timing: RTL

- Machine-cycle timing and instruction-fetch sequencer for the MCU51 core.
- Divides the 12 MHz clock into the 8051 machine cycle of 6 states x 2 phases (S1P1..S6P2).
- Drives ALE, PSEN, the code-ROM chip select, the IR latch, the operand latches (direct/rel/bit) and PC increment.
- Receives instruction length and cycle count from the opcode decoder, and tells the control unit when to execute.

---
 rtl/mcu51_fetch_timing.sv | 92 +++++++++
 1 files changed

// File: rtl/mcu51_fetch_timing.sv
// MCU51 machine-cycle timing: 12-tick machine cycle, fetch-slot strobes,
// ALE/PSEN generation and end-of-instruction execute pulse.
module mcu51_fetch_timing #(
   parameter int TICKS   = 12,
   parameter int MAX_CYC = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ea,
   input  logic [1:0] ins_len,
   input  logic [2:0] ins_cyc,
   output logic [2:0] state,
   output logic       phase,
   output logic [1:0] mcycle,
   output logic       ale,
   output logic       psen_n,
   output logic       code_cs,
   output logic       ir_en,
   output logic [1:0] opnd_en,
   output logic       pc_en,
   output logic       exec_en
);

   localparam logic [3:0] T_LAST  = 4'(TICKS - 1);
   localparam logic [2:0] CYC_MAX = 3'(MAX_CYC);

   logic [3:0] t, t_nxt;
   logic [1:0] mc_nxt, last_mc;
   logic [1:0] bytes_left;
   logic [2:0] cyc_total;
   logic [1:0] len_eff;
   logic [2:0] cyc_eff;
   logic       op_fetch, opnd_fetch, psen_low;

   assign state = t[3:1];
   assign phase = t[0];

   always_comb begin
      last_mc    = 2'(cyc_total - 3'd1);
      t_nxt      = (t == T_LAST) ? 4'd0 : t + 4'd1;
      mc_nxt     = (t == T_LAST) ? ((mcycle == last_mc) ? 2'd0 : mcycle + 2'd1) : mcycle;
      op_fetch   = (t_nxt == 4'd1) && (mc_nxt == 2'd0);
      opnd_fetch = ((t_nxt == 4'd1) || (t_nxt == 4'd7)) && !op_fetch && (bytes_left != 2'd0);
      // PSEN leads each real fetch slot by one clock; bytes_left is still
      // the pre-decrement count on both of those clocks.
      psen_low   = ((t_nxt <= 4'd1) && (mc_nxt == 2'd0)) ||
                   (((t_nxt <= 4'd1) || (t_nxt == 4'd6) || (t_nxt == 4'd7)) && (bytes_left != 2'd0));
      len_eff    = (ins_len == 2'd0) ? 2'd1 : ins_len;
      if (ins_cyc == 3'd0)
         cyc_eff = 3'd1;
      else if (ins_cyc > CYC_MAX)
         cyc_eff = CYC_MAX;
      else
         cyc_eff = ins_cyc;
      // A third byte can only be fetched in the next cycle's first slot.
      if ((ins_len == 2'd3) && (cyc_eff == 3'd1))
         cyc_eff = 3'd2;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         t          <= 4'd0;
         mcycle     <= 2'd0;
         bytes_left <= 2'd0;
         cyc_total  <= 3'd1;
         ale        <= 1'b0;
         psen_n     <= 1'b1;
         code_cs    <= 1'b0;
         ir_en      <= 1'b0;
         opnd_en    <= 2'b00;
         pc_en      <= 1'b0;
         exec_en    <= 1'b0;
      end else begin
         t       <= t_nxt;
         mcycle  <= mc_nxt;
         ale     <= (t_nxt == 4'd1) || (t_nxt == 4'd2) || (t_nxt == 4'd7) || (t_nxt == 4'd8);
         psen_n  <= ea || !psen_low;
         code_cs <= op_fetch || opnd_fetch;
         pc_en   <= op_fetch || opnd_fetch;
         ir_en   <= op_fetch;
         opnd_en <= {opnd_fetch && (t_nxt == 4'd1), opnd_fetch && (t_nxt == 4'd7)};
         exec_en <= (t_nxt == T_LAST) && (mc_nxt == last_mc);
         if ((t == 4'd2) && (mcycle == 2'd0)) begin
            bytes_left <= len_eff - 2'd1;
            cyc_total  <= cyc_eff;
         end else if (opnd_fetch) begin
            bytes_left <= bytes_left - 2'd1;
         end
      end
   end

endmodule
